// File: rtl/ysyx_23060332_mem_arbiter_if.sv
// rtl/ysyx_23060332_mem_arbiter_if.sv - IFU/LSU request/response channels and shared memory port
// master: the arbiter's view; slave: the requesters' and memory model's view.
interface ysyx_23060332_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_resp_valid;
  logic              ifu_resp_ready;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic              lsu_wen;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic [7:0]        lsu_wmask;
  logic              lsu_resp_valid;
  logic              lsu_resp_ready;
  logic [DATA_W-1:0] lsu_rdata;

  logic              mem_valid;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wmask;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata,
    input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_resp_ready,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata,
    output mem_valid, mem_wen, mem_waddr, mem_wdata, mem_wmask, mem_raddr,
    input  mem_rdata
  );

  modport slave (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
    output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask, lsu_resp_ready,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
    input  mem_valid, mem_wen, mem_waddr, mem_wdata, mem_wmask, mem_raddr,
    output mem_rdata
  );
endinterface

// File: rtl/ysyx_23060332_mem_arbiter.sv
// rtl/ysyx_23060332_mem_arbiter.sv - two-requester arbiter/sequencer in front of the shared memory port
// Define YSYX_23060332_ARB_RR_EN for round-robin arbitration; default is fixed LSU-over-IFU priority.
module ysyx_23060332_mem_arbiter #(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input logic                         clock,
  input logic                         rst_n,
  ysyx_23060332_mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic       OWN_IFU  = 1'b0;
  localparam logic       OWN_LSU  = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e            state_q;
  logic              owner_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [7:0]        wmask_q;
  logic [DATA_W-1:0] rdata_q;
  logic [3:0]        cnt_q;
  logic              mem_valid_q;
  logic              mem_wen_q;
  logic              ifu_resp_valid_q;
  logic              lsu_resp_valid_q;

  logic ifu_grant;
  logic lsu_grant;
  logic idle;
  logic resp_fire;

`ifdef YSYX_23060332_ARB_RR_EN
  logic last_grant_q;

  // On a tie the side that was not granted last time wins.
  always_comb begin
    ifu_grant = bus.ifu_req_valid && (!bus.lsu_req_valid || (last_grant_q == OWN_LSU));
    lsu_grant = bus.lsu_req_valid && !ifu_grant;
  end
`else
  always_comb begin
    lsu_grant = bus.lsu_req_valid;
    ifu_grant = bus.ifu_req_valid && !bus.lsu_req_valid;
  end
`endif

  assign idle      = (state_q == IDLE);
  assign resp_fire = (owner_q == OWN_LSU) ? bus.lsu_resp_ready : bus.ifu_resp_ready;

  assign bus.ifu_req_ready  = idle && ifu_grant;
  assign bus.lsu_req_ready  = idle && lsu_grant;
  assign bus.ifu_resp_valid = ifu_resp_valid_q;
  assign bus.lsu_resp_valid = lsu_resp_valid_q;
  assign bus.ifu_rdata      = (owner_q == OWN_IFU) ? rdata_q : '0;
  assign bus.lsu_rdata      = (owner_q == OWN_LSU) ? rdata_q : '0;
  assign bus.mem_valid      = mem_valid_q;
  assign bus.mem_wen        = mem_wen_q;
  assign bus.mem_waddr      = addr_q;
  assign bus.mem_raddr      = addr_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      owner_q          <= OWN_IFU;
      wen_q            <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      wmask_q          <= '0;
      rdata_q          <= '0;
      cnt_q            <= '0;
      mem_valid_q      <= 1'b0;
      mem_wen_q        <= 1'b0;
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
`ifdef YSYX_23060332_ARB_RR_EN
      last_grant_q     <= OWN_LSU;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (ifu_grant || lsu_grant) begin
            owner_q     <= lsu_grant;
            wen_q       <= lsu_grant && bus.lsu_wen;
            addr_q      <= lsu_grant ? bus.lsu_addr : bus.ifu_addr;
            wdata_q     <= lsu_grant ? bus.lsu_wdata : '0;
            wmask_q     <= lsu_grant ? bus.lsu_wmask : 8'h00;
            mem_valid_q <= 1'b1;
            mem_wen_q   <= lsu_grant && bus.lsu_wen;
            state_q     <= ISSUE;
`ifdef YSYX_23060332_ARB_RR_EN
            last_grant_q <= lsu_grant;
`endif
          end
        end
        ISSUE: begin
          // The single memory strobe: mem_rdata is combinational in this cycle.
          mem_valid_q <= 1'b0;
          mem_wen_q   <= 1'b0;
          rdata_q     <= wen_q ? '0 : bus.mem_rdata;
          cnt_q       <= CNT_INIT;
          if (LATENCY == 1) begin
            state_q          <= RESP;
            ifu_resp_valid_q <= (owner_q == OWN_IFU);
            lsu_resp_valid_q <= (owner_q == OWN_LSU);
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q          <= RESP;
            ifu_resp_valid_q <= (owner_q == OWN_IFU);
            lsu_resp_valid_q <= (owner_q == OWN_LSU);
          end
        end
        RESP: begin
          if (resp_fire) begin
            state_q          <= IDLE;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_23060332_mem_arbiter.sv
// tb/tb_ysyx_23060332_mem_arbiter.sv - self-checking bench for ysyx_23060332_mem_arbiter
// Two instances: LATENCY=3 (main scenarios, random traffic) and LATENCY=1 (fetch timing).
module tb_ysyx_23060332_mem_arbiter;
  localparam int LAT_A = 3;
  localparam int LAT_B = 1;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;
  bit m_last_lsu = 1'b1;

  ysyx_23060332_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  ysyx_23060332_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  ysyx_23060332_mem_arbiter #(.LATENCY(LAT_A), .ADDR_W(32), .DATA_W(32)) u_dut_a (
    .clock(clock), .rst_n(rst_n), .bus(bus_a));
  ysyx_23060332_mem_arbiter #(.LATENCY(LAT_B), .ADDR_W(32), .DATA_W(32)) u_dut_b (
    .clock(clock), .rst_n(rst_n), .bus(bus_b));

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus_a.mem_rdata = mem_fn(bus_a.mem_raddr);
  assign bus_b.mem_rdata = mem_fn(bus_b.mem_raddr);

  // Winner by the arbitration rule: fixed LSU priority, or alternate on ties.
  function automatic bit model_pick_lsu(input bit iv, input bit lv);
`ifdef YSYX_23060332_ARB_RR_EN
    if (iv && lv) return !m_last_lsu;
`endif
    return lv;
  endfunction

  logic prev_mv_a = 1'b0;
  always @(negedge clock) begin
    if (bus_a.mem_valid) begin
      n_total++;
      if (prev_mv_a) $display("FAIL mem_valid_single: high in consecutive cycles at cycle %0d, required one-cycle pulse", cyc);
      else n_pass++;
    end
    prev_mv_a = bus_a.mem_valid;
  end

  task automatic expect_txn(input string tag, input bit exp_lsu, input bit wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [7:0] wmask, input int delay,
                            input bit nxt_iv, input bit nxt_lv, output int acc, output int hs);
    logic [31:0] exp_rd;
    logic [31:0] got_wd;
    logic [31:0] got_rd;
    exp_rd = wen ? 32'h0 : mem_fn(addr);
    acc = -1;
    hs  = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      @(negedge clock);
      if (bus_a.ifu_req_ready || bus_a.lsu_req_ready) begin
        acc = cyc;
        n_total++;
        if ({bus_a.ifu_req_ready, bus_a.lsu_req_ready} !== {!exp_lsu, exp_lsu})
          $display("FAIL %s grant: got ifu/lsu ready %b%b, required %b%b", tag,
                   bus_a.ifu_req_ready, bus_a.lsu_req_ready, !exp_lsu, exp_lsu);
        else n_pass++;
      end
    end
    if (acc < 0) begin
      n_total++;
      $display("FAIL %s accept_timeout: got no req_ready in 20 cycles, required one", tag);
      bus_a.ifu_req_valid = 1'b0;
      bus_a.lsu_req_valid = 1'b0;
      @(posedge clock); #2;
      return;
    end
    m_last_lsu = exp_lsu;
    @(posedge clock); #2;
    bus_a.ifu_req_valid = nxt_iv;
    bus_a.lsu_req_valid = nxt_lv;
    @(negedge clock);
    got_wd = exp_lsu ? bus_a.mem_wdata : wdata;
    n_total++;
    if ({bus_a.mem_valid, bus_a.mem_wen, bus_a.mem_raddr, bus_a.mem_waddr, got_wd, bus_a.mem_wmask,
         bus_a.ifu_req_ready, bus_a.lsu_req_ready} !== {1'b1, wen, addr, addr, wdata, wmask, 2'b00})
      $display("FAIL %s issue: got v=%b wen=%b ra=%h wa=%h wd=%h wm=%h, required v=1 wen=%b ra=wa=%h wd=%h wm=%h",
               tag, bus_a.mem_valid, bus_a.mem_wen, bus_a.mem_raddr, bus_a.mem_waddr, got_wd,
               bus_a.mem_wmask, wen, addr, wdata, wmask);
    else n_pass++;
    for (int k = 1; k < LAT_A; k++) begin
      @(negedge clock);
      n_total++;
      if ({bus_a.mem_valid, bus_a.ifu_resp_valid, bus_a.lsu_resp_valid, bus_a.ifu_req_ready, bus_a.lsu_req_ready} !== 5'b0)
        $display("FAIL %s wait%0d: got mv/irv/lrv/irr/lrr=%b%b%b%b%b, required 00000", tag, k, bus_a.mem_valid,
                 bus_a.ifu_resp_valid, bus_a.lsu_resp_valid, bus_a.ifu_req_ready, bus_a.lsu_req_ready);
      else n_pass++;
    end
    for (int d = 0; d <= delay; d++) begin
      if (d > 0) @(negedge clock);
      else @(negedge clock);
      got_rd = exp_lsu ? bus_a.lsu_rdata : bus_a.ifu_rdata;
      n_total++;
      if ({bus_a.ifu_resp_valid, bus_a.lsu_resp_valid, got_rd, bus_a.mem_valid, bus_a.ifu_req_ready, bus_a.lsu_req_ready}
          !== {!exp_lsu, exp_lsu, exp_rd, 3'b000})
        $display("FAIL %s resp%0d: got irv=%b lrv=%b rdata=%h mv=%b rdy=%b%b, required irv=%b lrv=%b rdata=%h mv=0 rdy=00",
                 tag, d, bus_a.ifu_resp_valid, bus_a.lsu_resp_valid, got_rd, bus_a.mem_valid,
                 bus_a.ifu_req_ready, bus_a.lsu_req_ready, !exp_lsu, exp_lsu, exp_rd);
      else n_pass++;
    end
    if (exp_lsu) bus_a.lsu_resp_ready = 1'b1;
    else bus_a.ifu_resp_ready = 1'b1;
    hs = cyc;
    @(posedge clock); #2;
    bus_a.ifu_resp_ready = 1'b0;
    bus_a.lsu_resp_ready = 1'b0;
    n_total++;
    if ({bus_a.ifu_resp_valid, bus_a.lsu_resp_valid} !== 2'b00)
      $display("FAIL %s resp_drop: got irv/lrv=%b%b, required 00", tag, bus_a.ifu_resp_valid, bus_a.lsu_resp_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clock);
    @(negedge clock);
    n_total++;
    if ({bus_a.ifu_req_ready, bus_a.ifu_resp_valid, bus_a.ifu_rdata, bus_a.lsu_req_ready, bus_a.lsu_resp_valid,
         bus_a.lsu_rdata, bus_a.mem_valid, bus_a.mem_wen, bus_a.mem_waddr, bus_a.mem_wdata, bus_a.mem_wmask,
         bus_a.mem_raddr} !== 174'b0)
      $display("FAIL reset_outputs: got mv=%b wa=%h wd=%h irv=%b lrv=%b, required all zero", bus_a.mem_valid,
               bus_a.mem_waddr, bus_a.mem_wdata, bus_a.ifu_resp_valid, bus_a.lsu_resp_valid);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clock); #2;
  endtask

  task automatic test_fetch_lat1();
    int acc = -1;
    bus_b.ifu_addr      = 32'h8000_0000;
    bus_b.ifu_req_valid = 1'b1;
    for (int i = 0; i < 10 && acc < 0; i++) begin
      @(negedge clock);
      if (bus_b.ifu_req_ready) acc = cyc;
    end
    n_total++;
    if (acc < 0) $display("FAIL lat1_accept: got no ifu_req_ready, required one");
    else n_pass++;
    @(posedge clock); #2;
    bus_b.ifu_req_valid = 1'b0;
    @(negedge clock);
    n_total++;
    if ({bus_b.mem_valid, bus_b.mem_wen, bus_b.mem_raddr, bus_b.ifu_resp_valid} !== {1'b1, 1'b0, 32'h8000_0000, 1'b0})
      $display("FAIL lat1_issue: got mv=%b wen=%b ra=%h rv=%b, required mv=1 wen=0 ra=80000000 rv=0",
               bus_b.mem_valid, bus_b.mem_wen, bus_b.mem_raddr, bus_b.ifu_resp_valid);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if ({bus_b.mem_valid, bus_b.ifu_resp_valid, bus_b.ifu_rdata, bus_b.lsu_resp_valid} !== {1'b0, 1'b1, 32'h0000_0413, 1'b0})
      $display("FAIL lat1_resp: got mv=%b rv=%b rdata=%h lrv=%b, required mv=0 rv=1 rdata=00000413 lrv=0",
               bus_b.mem_valid, bus_b.ifu_resp_valid, bus_b.ifu_rdata, bus_b.lsu_resp_valid);
    else n_pass++;
    bus_b.ifu_resp_ready = 1'b1;
    @(posedge clock); #2;
    bus_b.ifu_resp_ready = 1'b0;
    n_total++;
    if (bus_b.ifu_resp_valid !== 1'b0) $display("FAIL lat1_resp_drop: got rv=%b, required 0", bus_b.ifu_resp_valid);
    else n_pass++;
  endtask

  task automatic test_directed();
    int acc, hs;
    bus_a.ifu_addr = 32'h8000_0000; bus_a.ifu_req_valid = 1'b1;
    expect_txn("ifu_fetch", 1'b0, 1'b0, 32'h8000_0000, 32'h0, 8'h00, 0, 1'b0, 1'b0, acc, hs);
    bus_a.lsu_addr = 32'h8000_1000; bus_a.lsu_wdata = 32'hDEAD_BEEF; bus_a.lsu_wmask = 8'h0F;
    bus_a.lsu_wen = 1'b1; bus_a.lsu_req_valid = 1'b1;
    expect_txn("lsu_store", 1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 8'h0F, 1, 1'b0, 1'b0, acc, hs);
    bus_a.lsu_addr = 32'h8000_2004; bus_a.lsu_wdata = 32'h0; bus_a.lsu_wmask = 8'h00;
    bus_a.lsu_wen = 1'b0; bus_a.lsu_req_valid = 1'b1;
    expect_txn("lsu_load", 1'b1, 1'b0, 32'h8000_2004, 32'h0, 8'h00, 2, 1'b0, 1'b0, acc, hs);
    bus_a.lsu_addr = 32'h8000_3000; bus_a.lsu_wdata = 32'h1234_5678; bus_a.lsu_wmask = 8'h00;
    bus_a.lsu_wen = 1'b1; bus_a.lsu_req_valid = 1'b1;
    expect_txn("store_mask0", 1'b1, 1'b1, 32'h8000_3000, 32'h1234_5678, 8'h00, 0, 1'b0, 1'b0, acc, hs);
  endtask

  task automatic test_simultaneous();
    int acc, hs;
    logic [2:0] seq;
    logic [2:0] seq_v;
    bit el;
`ifdef YSYX_23060332_ARB_RR_EN
    seq_v = 3'b010;
`else
    seq_v = 3'b111;
`endif
    seq = seq_v;
    bus_a.ifu_addr = 32'h8000_0100;
    bus_a.lsu_addr = 32'h8000_4000; bus_a.lsu_wen = 1'b0; bus_a.lsu_wdata = 32'h0; bus_a.lsu_wmask = 8'h00;
    bus_a.ifu_req_valid = 1'b1; bus_a.lsu_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      el = seq[i];
      expect_txn($sformatf("tie%0d", i), el, 1'b0, el ? 32'h8000_4000 : 32'h8000_0100, 32'h0, 8'h00, 0,
                 1'b1, (i < 2), acc, hs);
    end
    expect_txn("tie_lsu_dropped", 1'b0, 1'b0, 32'h8000_0100, 32'h0, 8'h00, 0, 1'b0, 1'b0, acc, hs);
  endtask

  task automatic test_backpressure();
    int acc, hs, acc2, hs2;
    bus_a.ifu_addr = 32'h8000_0200;
    bus_a.lsu_addr = 32'h8000_5008; bus_a.lsu_wen = 1'b0; bus_a.lsu_wdata = 32'h0; bus_a.lsu_wmask = 8'h00;
    bus_a.lsu_req_valid = 1'b1;
    expect_txn("bp_load", 1'b1, 1'b0, 32'h8000_5008, 32'h0, 8'h00, 5, 1'b1, 1'b0, acc, hs);
    expect_txn("bp_ifu", 1'b0, 1'b0, 32'h8000_0200, 32'h0, 8'h00, 0, 1'b0, 1'b0, acc2, hs2);
    n_total++;
    if (acc2 !== hs + 1) $display("FAIL bp_next_accept: got accept cycle %0d, required %0d", acc2, hs + 1);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      bit iv, lv, lw, pl;
      logic [31:0] ia, la, wd;
      logic [7:0] wm;
      int acc, hs;
      do begin
        iv = 1'($urandom_range(0, 1));
        lv = 1'($urandom_range(0, 1));
      end while (!iv && !lv);
      ia = {4'h8, 28'($urandom)} & 32'hFFFF_FFFC;
      la = {4'h8, 28'($urandom)};
      wd = $urandom;
      wm = 8'($urandom);
      lw = 1'($urandom_range(0, 1));
      pl = model_pick_lsu(iv, lv);
      bus_a.ifu_addr = ia; bus_a.lsu_addr = la; bus_a.lsu_wdata = wd; bus_a.lsu_wmask = wm; bus_a.lsu_wen = lw;
      bus_a.ifu_req_valid = iv; bus_a.lsu_req_valid = lv;
      expect_txn($sformatf("rand%0d", n), pl, pl && lw, pl ? la : ia, pl ? wd : 32'h0, pl ? wm : 8'h00,
                 $urandom_range(0, 3), 1'b0, 1'b0, acc, hs);
    end
  endtask

  task automatic test_reset_mid_wait();
    int acc = -1;
    int hs;
    bit pl;
    bus_a.lsu_addr = 32'h8000_6000; bus_a.lsu_wdata = 32'hCAFE_F00D; bus_a.lsu_wmask = 8'hFF;
    bus_a.lsu_wen = 1'b1; bus_a.lsu_req_valid = 1'b1;
    for (int i = 0; i < 10 && acc < 0; i++) begin
      @(negedge clock);
      if (bus_a.lsu_req_ready) acc = cyc;
    end
    n_total++;
    if (acc < 0) $display("FAIL rst_accept: got no lsu_req_ready, required one");
    else n_pass++;
    @(posedge clock); #2;
    bus_a.lsu_req_valid = 1'b0;
    bus_a.lsu_resp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b0;
    @(negedge clock);
    n_total++;
    if ({bus_a.ifu_req_ready, bus_a.ifu_resp_valid, bus_a.ifu_rdata, bus_a.lsu_req_ready, bus_a.lsu_resp_valid,
         bus_a.lsu_rdata, bus_a.mem_valid, bus_a.mem_wen, bus_a.mem_waddr, bus_a.mem_wdata, bus_a.mem_wmask,
         bus_a.mem_raddr} !== 174'b0)
      $display("FAIL rst_mid_wait: got mv=%b wa=%h wd=%h wm=%h lrv=%b, required all zero", bus_a.mem_valid,
               bus_a.mem_waddr, bus_a.mem_wdata, bus_a.mem_wmask, bus_a.lsu_resp_valid);
    else n_pass++;
    rst_n = 1'b1;
    m_last_lsu = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      n_total++;
      if ({bus_a.mem_valid, bus_a.ifu_resp_valid, bus_a.lsu_resp_valid} !== 3'b000)
        $display("FAIL rst_no_resp%0d: got mv/irv/lrv=%b%b%b, required 000", i, bus_a.mem_valid,
                 bus_a.ifu_resp_valid, bus_a.lsu_resp_valid);
      else n_pass++;
    end
    @(posedge clock); #2;
    bus_a.lsu_resp_ready = 1'b0;
    pl = model_pick_lsu(1'b1, 1'b1);
    bus_a.ifu_addr = 32'h8000_0300;
    bus_a.lsu_addr = 32'h8000_7000; bus_a.lsu_wen = 1'b0; bus_a.lsu_wdata = 32'h0; bus_a.lsu_wmask = 8'h00;
    bus_a.ifu_req_valid = 1'b1; bus_a.lsu_req_valid = 1'b1;
    expect_txn("post_rst_tie", pl, 1'b0, pl ? 32'h8000_7000 : 32'h8000_0300, 32'h0, 8'h00, 0, 1'b0, 1'b0, acc, hs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_a.ifu_req_valid = 1'b0; bus_a.ifu_addr = '0; bus_a.ifu_resp_ready = 1'b0;
    bus_a.lsu_req_valid = 1'b0; bus_a.lsu_wen = 1'b0; bus_a.lsu_addr = '0;
    bus_a.lsu_wdata = '0; bus_a.lsu_wmask = '0; bus_a.lsu_resp_ready = 1'b0;
    bus_b.ifu_req_valid = 1'b0; bus_b.ifu_addr = '0; bus_b.ifu_resp_ready = 1'b0;
    bus_b.lsu_req_valid = 1'b0; bus_b.lsu_wen = 1'b0; bus_b.lsu_addr = '0;
    bus_b.lsu_wdata = '0; bus_b.lsu_wmask = '0; bus_b.lsu_resp_ready = 1'b0;
    test_reset();
    test_fetch_lat1();
    test_directed();
    test_simultaneous();
    test_backpressure();
    test_random();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ysyx_23060332_mem_arbiter.md
Name: ysyx_23060332_mem_arbiter

Overview:
Two-requester arbiter and sequencer in front of the shared DPI-C memory port, which carries mem_valid, mem_wen, waddr, wdata, wmask, raddr and rdata.
- Accepts fetch reads from the IFU and load/store requests from the LSU.
- Grants one request at a time and drives exactly one single-cycle memory access per transaction.
- Models a configurable access latency, then returns a response to the owner over valid/ready.
- Sits between the IFU/LSU and the memory module. It is the only driver of the memory port.

Parameters:
- LATENCY, 1, cycles from the ISSUE cycle to the first response-valid cycle; legal range 1..15.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted on valid&&ready.
- ifu_addr  in  ADDR_W  fetch address.
- ifu_resp_valid  out  1  IFU read data valid.
- ifu_resp_ready  in  1  IFU consumes the response.
- ifu_rdata  out  DATA_W  fetch data.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted on valid&&ready.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_addr  in  ADDR_W  load/store address.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  8  store byte mask.
- lsu_resp_valid  out  1  load data valid or store acknowledge.
- lsu_resp_ready  in  1  LSU consumes the response.
- lsu_rdata  out  DATA_W  load data; 0 for stores.
- mem_valid  out  1  memory access strobe.
- mem_wen  out  1  memory write enable.
- mem_waddr  out  ADDR_W  write address.
- mem_wdata  out  DATA_W  write data.
- mem_wmask  out  8  write mask.
- mem_raddr  out  ADDR_W  read address.
- mem_rdata  in  DATA_W  read data; combinational, valid in the same cycle as mem_valid.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Reset values: all outputs 0, all latched request registers 0, counter 0.
- Reset mid-transaction returns to IDLE immediately. The in-flight transaction is dropped: no response and no retry. A store already issued stays performed.
- IDLE:
  - req_ready is high combinationally, only for the arbitration winner among requesters with valid=1.
  - The loser's ready is 0. Both readys are 0 when no requester is valid.
  - On the handshake edge: latch owner, wen (IFU forces 0), addr, wdata, wmask (IFU forces 0), then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_valid=1; mem_wen=latched wen.
  - mem_raddr = mem_waddr = latched addr; mem_wdata and mem_wmask from latches.
  - At the edge, capture mem_rdata into the response register (0 if wen=1).
  - Load counter with LATENCY-1. Go to RESP if LATENCY==1, else WAIT.
- WAIT:
  - mem_valid=0; address/data outputs hold latched values.
  - Counter decrements each cycle; go to RESP when the counter reaches 1→0.
- RESP:
  - The owner's resp_valid=1 and rdata = captured value. The non-owner's resp_valid stays 0.
  - Held stable until resp_ready=1. On that edge go to IDLE.
- No request is accepted outside IDLE. The earliest next accept is the cycle after the response handshake.
- Latency: accept edge T → ISSUE cycle T+1 → resp_valid first high in cycle T+1+LATENCY.
- Arbitration (default): fixed priority, LSU over IFU.
- Stores with wmask=0 pass through unchanged. A write with mem_wmask=0 is still issued.
- mem_valid is never high for more than one consecutive cycle, so each DPI pmem_write fires once per store.

Optional Feature:
- Macro: YSYX_23060332_ARB_RR_EN.
- Defined: two-way round-robin arbitration.
  - A last_grant register is updated on every accept; reset value = LSU, so IFU wins the first tie.
  - On a tie, the requester not granted last wins.
  - A single requester always wins.
- Undefined: fixed LSU>IFU priority and no last_grant register.

Test Plan:
- Reset/idle: rst_n=0 mid-WAIT with LATENCY=3 → next cycle all outputs 0, state IDLE, no resp_valid thereafter.
- IFU fetch, LATENCY=1: ifu_addr=0x80000000, mem_rdata=0x00000413 → mem_valid high 1 cycle with mem_raddr=0x80000000, mem_wen=0; ifu_resp_valid next cycle with ifu_rdata=0x00000413.
- LSU store, LATENCY=3: addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F → single mem_valid cycle with mem_wen=1 and matching waddr/wdata/wmask; lsu_resp_valid 3 cycles after ISSUE; lsu_rdata=0.
- Simultaneous requests, fixed priority: both valid for 3 transactions → order LSU, LSU, LSU. IFU is granted only after LSU drops valid.
- Same with YSYX_23060332_ARB_RR_EN: grants IFU, LSU, IFU. ifu_req_ready and lsu_req_ready are never high together.
- Backpressure: hold lsu_resp_ready=0 for 5 cycles → lsu_resp_valid and lsu_rdata stable, no new accept while ifu_req_valid=1, no extra mem_valid pulses; IFU accepted the cycle after resp_ready=1.
